// File: rtl/detector_jogada.sv
// rtl/detector_jogada.sv - synchronizes, debounces and encodes player answer buttons into jogada/timeout/multiplo pulses
module detector_jogada #(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CICLOS = 20,
    parameter int TIMEOUT_CICLOS  = 5000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        habilita,
    input  logic [N_BOTOES-1:0]         botoes,
    output logic                        jogada,
    output logic [$clog2(N_BOTOES)-1:0] codigo,
    output logic                        timeout,
    output logic                        multiplo,
    output logic [2:0]                  db_estado
);

    localparam int CW  = $clog2(N_BOTOES);
    localparam int TW  = $clog2(TIMEOUT_CICLOS);
    localparam int CNW = $clog2(DEBOUNCE_CICLOS);

    localparam logic [TW-1:0]  TIMER_MAX = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [CNW-1:0] CONT_MAX  = CNW'(DEBOUNCE_CICLOS - 1);

    typedef enum logic [2:0] {
        OCIOSO       = 3'd0,
        ARMADO       = 3'd1,
        FILTRA       = 3'd2,
        EMITE        = 3'd3,
        INVALIDO     = 3'd4,
        TEMPO        = 3'd5,
        ESPERA_SOLTA = 3'd6
    } estado_t;

    estado_t            estado;
    estado_t            proximo;
    logic [N_BOTOES-1:0] sinc1;
    logic [N_BOTOES-1:0] s;
    logic [N_BOTOES-1:0] padrao;
    logic [CNW-1:0]     contador;
    logic [CNW-1:0]     contador_prox;
    logic [TW-1:0]      timer;
    logic [TW-1:0]      timer_prox;
    logic [TW-1:0]      timer_inc;
    logic [CW-1:0]      indice;
    logic               carrega_padrao;

    // Two-flop synchronizer per button; only the second stage feeds the FSM
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc1 <= '0;
            s     <= '0;
        end else begin
            sinc1 <= botoes;
            s     <= sinc1;
        end
    end

    // Position of the set bit in the latched pattern (only meaningful when one-hot)
    always_comb begin
        indice = '0;
        for (int i = 0; i < N_BOTOES; i++) begin
            if (padrao[i]) begin
                indice = CW'(i);
            end
        end
    end

    // Answer window timer saturates at its limit so a late bounce back to ARMADO still times out
    always_comb begin
        timer_inc = (timer == TIMER_MAX) ? timer : timer + TW'(1);
    end

    // Next-state, counter/timer update and decoded pulse outputs
    always_comb begin
        proximo        = estado;
        contador_prox  = contador;
        timer_prox     = '0;
        carrega_padrao = 1'b0;
        jogada         = 1'b0;
        multiplo       = 1'b0;
        timeout        = 1'b0;

        case (estado)
            OCIOSO: begin
                contador_prox = '0;
                if (habilita) begin
                    // A button already down when armed must be released first
                    proximo = (s == '0) ? ARMADO : ESPERA_SOLTA;
                end
            end
            ARMADO: begin
                timer_prox = timer_inc;
                if (!habilita) begin
                    proximo = OCIOSO;
                end else if (s != '0) begin
                    proximo        = FILTRA;
                    carrega_padrao = 1'b1;
                end else if (timer == TIMER_MAX) begin
                    proximo = TEMPO;
                end
            end
            FILTRA: begin
                timer_prox = timer_inc;
                if (!habilita) begin
                    proximo = OCIOSO;
                end else if (s != padrao) begin
                    // Bounce: restart debounce but keep the answer window running
                    proximo = ARMADO;
                end else if (contador == CONT_MAX) begin
                    proximo = $onehot(padrao) ? EMITE : INVALIDO;
                end else if (timer == TIMER_MAX) begin
                    proximo = TEMPO;
                end else begin
                    contador_prox = contador + CNW'(1);
                end
            end
            EMITE: begin
                jogada  = 1'b1;
                proximo = ESPERA_SOLTA;
            end
            INVALIDO: begin
                multiplo = 1'b1;
                proximo  = ESPERA_SOLTA;
            end
            TEMPO: begin
                timeout = 1'b1;
                proximo = ESPERA_SOLTA;
            end
            ESPERA_SOLTA: begin
                if (s != '0) begin
                    contador_prox = '0;
                end else if (contador == CONT_MAX) begin
                    proximo = OCIOSO;
                end else begin
                    contador_prox = contador + CNW'(1);
                end
            end
            default: begin
                proximo = OCIOSO;
            end
        endcase

        // Counter always starts from zero in whichever state comes next
        if (proximo != estado) begin
            contador_prox = '0;
        end
        // Timer only lives across ARMADO/FILTRA
        if (proximo != ARMADO && proximo != FILTRA) begin
            timer_prox = '0;
        end
    end

    assign db_estado = estado;

    // State, counters, latched pattern and held answer code
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= OCIOSO;
            contador <= '0;
            timer    <= '0;
            padrao   <= '0;
            codigo   <= '0;
        end else begin
            estado   <= proximo;
            contador <= contador_prox;
            timer    <= timer_prox;
            if (carrega_padrao) begin
                padrao <= s;
            end
            if (proximo == EMITE) begin
                codigo <= indice;
            end
        end
    end

endmodule

// File: tb/tb_detector_jogada.sv
// tb/tb_detector_jogada.sv - table-driven check of detector_jogada with short debounce and timeout
module tb_detector_jogada;

    logic       clock;
    logic       reset;
    logic       habilita;
    logic [3:0] botoes;
    logic       jogada;
    logic [1:0] codigo;
    logic       timeout;
    logic       multiplo;
    logic [2:0] db_estado;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       h;
        logic [3:0] b;
        logic       j;
        logic       t;
        logic       m;
        logic [1:0] c;
        logic [2:0] e;
    } vec_t;

    vec_t tab[$];

    detector_jogada #(
        .N_BOTOES       (4),
        .DEBOUNCE_CICLOS(4),
        .TIMEOUT_CICLOS (50)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .habilita (habilita),
        .botoes   (botoes),
        .jogada   (jogada),
        .codigo   (codigo),
        .timeout  (timeout),
        .multiplo (multiplo),
        .db_estado(db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input int n, input logic h, input logic [3:0] b,
                       input logic j, input logic t, input logic m,
                       input logic [1:0] c, input logic [2:0] e);
        vec_t v;
        v.h = h; v.b = b; v.j = j; v.t = t; v.m = m; v.c = c; v.e = e;
        for (int k = 0; k < n; k++) tab.push_back(v);
    endtask

    function automatic int outs();
        return int'({jogada, timeout, multiplo, codigo, db_estado});
    endfunction

    initial begin
        int n;
        bit found;
        vec_t v;

        // Each row: inputs applied, one clock edge, then {j,t,m,codigo,estado} compared
        add(2, 0, 4'b0000, 0, 0, 0, 0, 0);
        // Clean press of button 2
        add(1, 1, 4'b0000, 0, 0, 0, 0, 1);
        add(2, 1, 4'b0100, 0, 0, 0, 0, 1);
        add(4, 1, 4'b0100, 0, 0, 0, 0, 2);
        add(1, 1, 4'b0100, 1, 0, 0, 2, 3);
        add(3, 1, 4'b0100, 0, 0, 0, 2, 6);
        add(5, 0, 4'b0000, 0, 0, 0, 2, 6);
        add(1, 0, 4'b0000, 0, 0, 0, 2, 0);
        // Bounce then stable press
        add(1, 1, 4'b0000, 0, 0, 0, 2, 1);
        add(2, 1, 4'b0100, 0, 0, 0, 2, 1);
        add(2, 1, 4'b0000, 0, 0, 0, 2, 2);
        add(2, 1, 4'b0100, 0, 0, 0, 2, 1);
        add(2, 1, 4'b0000, 0, 0, 0, 2, 2);
        add(2, 1, 4'b0100, 0, 0, 0, 2, 1);
        add(4, 1, 4'b0100, 0, 0, 0, 2, 2);
        add(1, 1, 4'b0100, 1, 0, 0, 2, 3);
        add(1, 1, 4'b0100, 0, 0, 0, 2, 6);
        add(5, 0, 4'b0000, 0, 0, 0, 2, 6);
        add(1, 0, 4'b0000, 0, 0, 0, 2, 0);
        // Two buttons together: rejected, codigo kept
        add(1, 1, 4'b0000, 0, 0, 0, 2, 1);
        add(2, 1, 4'b0011, 0, 0, 0, 2, 1);
        add(4, 1, 4'b0011, 0, 0, 0, 2, 2);
        add(1, 1, 4'b0011, 0, 0, 1, 2, 4);
        add(1, 1, 4'b0011, 0, 0, 0, 2, 6);
        add(5, 0, 4'b0000, 0, 0, 0, 2, 6);
        add(1, 0, 4'b0000, 0, 0, 0, 2, 0);
        // Timeout after 50 cycles in ARMADO; ESPERA_SOLTA ignores habilita
        add(50, 1, 4'b0000, 0, 0, 0, 2, 1);
        add(1, 1, 4'b0000, 0, 1, 0, 2, 5);
        add(4, 1, 4'b0000, 0, 0, 0, 2, 6);
        add(1, 1, 4'b0000, 0, 0, 0, 2, 0);
        add(1, 0, 4'b0000, 0, 0, 0, 2, 0);
        // Button already held when armed
        add(3, 0, 4'b0001, 0, 0, 0, 2, 0);
        add(3, 1, 4'b0001, 0, 0, 0, 2, 6);
        add(5, 1, 4'b0000, 0, 0, 0, 2, 6);
        add(1, 1, 4'b0000, 0, 0, 0, 2, 0);
        add(1, 1, 4'b0000, 0, 0, 0, 2, 1);
        add(2, 1, 4'b0001, 0, 0, 0, 2, 1);
        add(4, 1, 4'b0001, 0, 0, 0, 2, 2);
        add(1, 1, 4'b0001, 1, 0, 0, 0, 3);
        add(1, 1, 4'b0001, 0, 0, 0, 0, 6);
        add(5, 0, 4'b0000, 0, 0, 0, 0, 6);
        add(1, 0, 4'b0000, 0, 0, 0, 0, 0);
        // habilita drops while filtering
        add(1, 1, 4'b0000, 0, 0, 0, 0, 1);
        add(2, 1, 4'b1000, 0, 0, 0, 0, 1);
        add(1, 1, 4'b1000, 0, 0, 0, 0, 2);
        add(4, 0, 4'b1000, 0, 0, 0, 0, 0);
        add(2, 0, 4'b0000, 0, 0, 0, 0, 0);

        reset    = 1'b0;
        habilita = 1'b0;
        botoes   = 4'b0000;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_state", outs(), 0);
        reset = 1'b1;

        for (int i = 0; i < tab.size(); i++) begin
            v = tab[i];
            habilita = v.h;
            botoes   = v.b;
            step();
            chk($sformatf("row%0d", i), outs(),
                int'({v.j, v.t, v.m, v.c, v.e}));
        end

        // Press button 3, then reset while in ESPERA_SOLTA
        habilita = 1'b1;
        botoes   = 4'b0000;
        step();
        botoes = 4'b1000;
        n = 0;
        found = 0;
        while (n < 20 && !found) begin
            step();
            n++;
            if (jogada) found = 1;
        end
        chk("latency_b3", n, 7);
        chk("codigo_b3", int'(codigo), 3);
        step();
        chk("espera_b3", int'(db_estado), 6);
        #2 reset = 1'b0;
        #1 chk("reset_espera", outs(), 0);
        @(posedge clock);
        #1 reset = 1'b1;
        habilita = 1'b0;
        botoes   = 4'b0000;
        repeat (3) step();
        chk("after_reset", outs(), 0);

        // Reset during the EMITE cycle drops the pulse immediately
        habilita = 1'b1;
        step();
        botoes = 4'b0010;
        n = 0;
        found = 0;
        while (n < 20 && !found) begin
            step();
            n++;
            if (jogada) found = 1;
        end
        chk("latency_b1", n, 7);
        chk("codigo_b1", int'(codigo), 1);
        #1 reset = 1'b0;
        #1 chk("reset_emite", outs(), 0);
        @(posedge clock);
        #1 reset = 1'b1;
        habilita = 1'b0;
        botoes   = 4'b0000;
        repeat (6) step();
        chk("final_idle", outs(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/detector_jogada.md
Name: detector_jogada

Overview:
- Input-conditioning stage directly upstream of the game control unit.
- Synchronizes and debounces the player answer buttons and encodes a single valid press into an answer code.
- Drives the control unit's `jogada` and `timeout` inputs as 1-cycle pulses.
- Armed by the control unit only while it waits for a play, via `habilita`, which is high during ESPERA_JOGADA.

Parameters:
- N_BOTOES, 4: number of answer buttons (≥2).
- DEBOUNCE_CICLOS, 20: consecutive stable cycles required to accept a press or a release (≥2).
- TIMEOUT_CICLOS, 5000: cycles allowed in ARMADO/FILTRA before `timeout` fires (≥2).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low: reset=0 forces reset state immediately.
- habilita  in  1  control unit is waiting for a play.
- botoes  in  N_BOTOES  raw buttons, asynchronous, active-high.
- jogada  out  1  1-cycle pulse: valid single-button press accepted.
- codigo  out  $clog2(N_BOTOES)  index of the accepted button; held until the next jogada.
- timeout  out  1  1-cycle pulse: no valid press within TIMEOUT_CICLOS.
- multiplo  out  1  1-cycle pulse: debounced press had more than one button (rejected).
- db_estado  out  3  current FSM state code.

Behaviour:
- Reset (reset=0):
  - state OCIOSO.
  - sync flops, latched pattern, debounce counter and timer all 0.
  - jogada=0, timeout=0, multiplo=0, codigo=0, db_estado=0.
- Synchronizer: 2 flops per bit. FSM uses only the 2nd stage (`s`).
- All outputs are registered or decoded from state; no combinational path from `botoes`.
- States (code):
  - OCIOSO(0):
    - timer and debounce counter cleared.
    - habilita=1 and s==0 → ARMADO.
    - habilita=1 and s!=0 → ESPERA_SOLTA (button already held; never accept it as a press).
  - ARMADO(1):
    - timer increments each cycle.
    - habilita=0 → OCIOSO.
    - else s!=0 → FILTRA, latch `p`=s, counter=0.
    - else timer==TIMEOUT_CICLOS-1 → TEMPO.
  - FILTRA(2):
    - timer keeps incrementing.
    - habilita=0 → OCIOSO.
    - s!=p → ARMADO with counter cleared; the timer is not cleared.
    - counter==DEBOUNCE_CICLOS-1 → EMITE if p is one-hot, else INVALIDO.
    - else counter+1.
    - Debounce completion and timer expiry in the same cycle: completion wins.
    - Timer expiry alone → TEMPO.
  - EMITE(3): jogada=1; codigo ← index of the set bit of p. Next state ESPERA_SOLTA.
  - INVALIDO(4): multiplo=1; codigo unchanged. Next state ESPERA_SOLTA.
  - TEMPO(5): timeout=1. Next state ESPERA_SOLTA.
  - ESPERA_SOLTA(6):
    - ignores habilita.
    - counter increments while s==0 and resets to 0 when s!=0.
    - counter==DEBOUNCE_CICLOS-1 with s==0 → OCIOSO.
- Latency: with pin stable from clock edge e0 (first edge sampling the pressed value), FILTRA is entered at e0+2 and EMITE at e0+2+DEBOUNCE_CICLOS. jogada is high for exactly the cycle after that edge.
- A state is held at most one cycle in EMITE/INVALIDO/TEMPO, so each event produces exactly one pulse.
- At most one of jogada, multiplo, timeout is high in any cycle.
- Timer width: $clog2(TIMEOUT_CICLOS). Counter width: $clog2(DEBOUNCE_CICLOS). Neither wraps: both are cleared on leaving their states.
- Reset asserted mid-operation, including during an EMITE cycle: pulse dropped immediately; codigo returns to 0.
- Bouncing during FILTRA restarts the debounce only; the total answer window is still bounded by TIMEOUT_CICLOS.

Test Plan (bench uses DEBOUNCE_CICLOS=4, TIMEOUT_CICLOS=50, N_BOTOES=4):
- Clean press: habilita=1, botoes=4'b0100 held 10 cycles → one jogada pulse 6 cycles after the first sampling edge; codigo=2. After release plus 4 cycles, db_estado=0.
- Bounce: botoes toggles 0100/0000 every 2 cycles for 8 cycles, then holds 0100 → no pulse during bouncing; single jogada with codigo=2 after 4 stable cycles.
- Multiple buttons: botoes=4'b0011 held → multiplo pulses once; jogada stays 0; codigo keeps its previous value.
- Timeout: habilita=1, no press → timeout pulses once 50 cycles after entering ARMADO; then db_estado=6, followed by 0 after 4 idle cycles.
- Held at arm: botoes=4'b0001 already high when habilita rises → state ESPERA_SOLTA; no jogada until released and pressed again.
- Reset/disable: habilita falls mid-FILTRA → OCIOSO with no pulse. reset=0 for 1 cycle mid-ESPERA_SOLTA → all outputs 0 and db_estado=0 immediately.
